// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (optional VGA_TIMING_PIPELINE_EN delays sync/blank)
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FPORCH   = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BPORCH   = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FPORCH   = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BPORCH   = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   COORD_W    = 10,
    parameter int   PIPE_DEPTH = 2
) (
    input  logic               pxl_clk_i,
    input  logic               reset_async_n_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               blank_o,
    output logic               line_start_o,
    output logic               frame_start_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL  = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
    localparam int HS_BEG   = H_ACTIVE + H_FPORCH;
    localparam int HS_END   = H_ACTIVE + H_FPORCH + H_SYNC;
    localparam int VS_BEG   = V_ACTIVE + V_FPORCH;
    localparam int VS_END   = V_ACTIVE + V_FPORCH + V_SYNC;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    // Reject geometries the counters cannot hold, and an empty pipeline
    if (H_TOTAL > 2**COORD_W || V_TOTAL > 2**COORD_W || PIPE_DEPTH < 1) begin : g_param_check
        $error("vga_timing_gen: invalid parameter set");
    end

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_hs;
    logic               r_vs;
    logic               r_bl;
    logic               r_ls;
    logic               r_fs;

    logic               w_x_wrap;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic               w_hs_nxt;
    logic               w_vs_nxt;
    logic               w_bl_nxt;

    // Next raster position and its decode, so every flop describes the same (x,y)
    always_comb begin
        w_x_wrap = (r_x == H_LAST);
        w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_nxt  = r_y;
        if (w_x_wrap) begin
            w_y_nxt = (r_y == V_LAST) ? '0 : r_y + 1'b1;
        end
        w_hs_nxt = (int'(w_x_nxt) >= HS_BEG && int'(w_x_nxt) < HS_END) ? SYNC_POL : ~SYNC_POL;
        w_vs_nxt = (int'(w_y_nxt) >= VS_BEG && int'(w_y_nxt) < VS_END) ? SYNC_POL : ~SYNC_POL;
        w_bl_nxt = (int'(w_x_nxt) >= H_ACTIVE) || (int'(w_y_nxt) >= V_ACTIVE);
    end

    // Raster counters and decoded outputs; reset restarts at (0,0) with sync inactive
    always_ff @(posedge pxl_clk_i or negedge reset_async_n_i) begin
        if (!reset_async_n_i) begin
            r_x  <= '0;
            r_y  <= '0;
            r_hs <= ~SYNC_POL;
            r_vs <= ~SYNC_POL;
            r_bl <= 1'b0;
            r_ls <= 1'b1;
            r_fs <= 1'b1;
        end else begin
            r_x  <= w_x_nxt;
            r_y  <= w_y_nxt;
            r_hs <= w_hs_nxt;
            r_vs <= w_vs_nxt;
            r_bl <= w_bl_nxt;
            r_ls <= (w_x_nxt == '0);
            r_fs <= (w_x_nxt == '0) && (w_y_nxt == '0);
        end
    end

    assign x_o           = r_x;
    assign y_o           = r_y;
    assign line_start_o  = r_ls;
    assign frame_start_o = r_fs;

`ifdef VGA_TIMING_PIPELINE_EN
    // {hsync, vsync, blank} per stage
    logic [2:0] r_pipe [PIPE_DEPTH];

    // Delay sync/blank to line up with pixel data fetched from x_o/y_o
    always_ff @(posedge pxl_clk_i or negedge reset_async_n_i) begin
        if (!reset_async_n_i) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_pipe[i] <= {~SYNC_POL, ~SYNC_POL, 1'b1};
            end
        end else begin
            r_pipe[0] <= {r_hs, r_vs, r_bl};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign hsync_o = r_pipe[PIPE_DEPTH-1][2];
    assign vsync_o = r_pipe[PIPE_DEPTH-1][1];
    assign blank_o = r_pipe[PIPE_DEPTH-1][0];
`else
    assign hsync_o = r_hs;
    assign vsync_o = r_vs;
    assign blank_o = r_bl;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen, full VGA and tiny raster
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPELINE_EN
    localparam int PIPE_LAT = 2;
`else
    localparam int PIPE_LAT = 0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       ls;
        logic       fs;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n = 0;
    int         total = 0;
    int         bad = 0;

    logic [9:0] x1, y1, x2, y2;
    logic       hs1, vs1, bl1, ls1, fs1;
    logic       hs2, vs2, bl2, ls2, fs2;
    vec_t       e1, e2;

    vga_timing_gen u_dut_vga (
        .pxl_clk_i(clk), .reset_async_n_i(rst_n),
        .x_o(x1), .y_o(y1), .hsync_o(hs1), .vsync_o(vs1), .blank_o(bl1),
        .line_start_o(ls1), .frame_start_o(fs1)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FPORCH(1), .H_SYNC(1), .H_BPORCH(1),
        .V_ACTIVE(2), .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1)
    ) u_dut_tiny (
        .pxl_clk_i(clk), .reset_async_n_i(rst_n),
        .x_o(x2), .y_o(y2), .hsync_o(hs2), .vsync_o(vs2), .blank_o(bl2),
        .line_start_o(ls2), .frame_start_o(fs2)
    );

    always #20 clk = ~clk;

    // Cycles elapsed since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at n=%0d", nm, act, exp, n);
        end
    endtask

    // Raster position is cycle count folded into the frame; sync/blank come from the same rules,
    // looked up PIPE_LAT cycles earlier (inactive sync, blank=1 before that history exists)
    function automatic vec_t model(input int cyc, input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb);
        vec_t v;
        int ht, vt, c, m, xm, ym;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        c = cyc % (ht * vt);
        v.x  = 10'(c % ht);
        v.y  = 10'(c / ht);
        v.ls = (c % ht == 0);
        v.fs = (c == 0);
        m = cyc - PIPE_LAT;
        if (m < 0) begin
            v.hs = 1'b1;
            v.vs = 1'b1;
            v.bl = 1'b1;
        end else begin
            c  = m % (ht * vt);
            xm = c % ht;
            ym = c / ht;
            v.hs = !(xm >= ha + hf && xm < ha + hf + hsw);
            v.vs = !(ym >= va + vf && ym < va + vf + vsw);
            v.bl = (xm >= ha) || (ym >= va);
        end
        return v;
    endfunction

    // Every-cycle comparison against the model, plus literal pins of the model itself
    always @(negedge clk) begin
        e1 = model(n, 640, 16, 96, 48, 480, 10, 2, 33);
        e2 = model(n, 4, 1, 1, 1, 2, 1, 1, 1);
        check("vga_x", 32'(x1), 32'(e1.x));
        check("vga_y", 32'(y1), 32'(e1.y));
        check("vga_hsync", 32'(hs1), 32'(e1.hs));
        check("vga_vsync", 32'(vs1), 32'(e1.vs));
        check("vga_blank", 32'(bl1), 32'(e1.bl));
        check("vga_line_start", 32'(ls1), 32'(e1.ls));
        check("vga_frame_start", 32'(fs1), 32'(e1.fs));
        check("tiny_x", 32'(x2), 32'(e2.x));
        check("tiny_y", 32'(y2), 32'(e2.y));
        check("tiny_hsync", 32'(hs2), 32'(e2.hs));
        check("tiny_vsync", 32'(vs2), 32'(e2.vs));
        check("tiny_blank", 32'(bl2), 32'(e2.bl));
        check("tiny_line_start", 32'(ls2), 32'(e2.ls));
        check("tiny_frame_start", 32'(fs2), 32'(e2.fs));
        if (rst_n) begin
            if (n == 0)   check("pin_first_line_start", 32'(ls1), 32'd1);
            if (n == 1)   check("pin_line_start_1cyc", 32'(ls1), 32'd0);
            if (n == 655) check("pin_hs_655", 32'(hs1), 32'd1);
            if (n == 658) check("pin_hs_658", 32'(hs1), 32'd0);
            if (n == 752) check("pin_hs_752", 32'(hs1), (PIPE_LAT == 0) ? 32'd1 : 32'd0);
            if (n == 799) check("pin_x_799", 32'(x1), 32'd799);
            if (n == 800) check("pin_y_step", 32'(y1), 32'd1);
            if (n == 800) check("pin_x_wrap", 32'(x1), 32'd0);
            if (n == 1)   check("pin_blank_after_rel", 32'(bl1), (PIPE_LAT == 0) ? 32'd0 : 32'd1);
            if (n == 5)   check("pin_tiny_hs_x5", 32'(hs2), (PIPE_LAT == 0) ? 32'd0 : 32'd1);
            if (n == 34)  check("pin_tiny_last_x", 32'(x2), 32'd6);
            if (n == 34)  check("pin_tiny_last_y", 32'(y2), 32'd4);
            if (n == 35)  check("pin_tiny_frame_wrap", 32'(fs2), 32'd1);
            if (n == 36)  check("pin_tiny_frame_1cyc", 32'(fs2), 32'd0);
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2000) @(negedge clk);

        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (x1 == 10'd700) found = 1'b1;
        end
        check("reach_x700", 32'(found), 32'd1);

        #5 rst_n = 1'b0;
        #1;
        check("async_x", 32'(x1), 32'd0);
        check("async_y", 32'(y1), 32'd0);
        check("async_hsync", 32'(hs1), 32'd1);
        check("async_tiny_x", 32'(x2), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (1700) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
